dt_xbar: RTL

DT_XBAR -- requirements
Module: dt_xbar

---
 rtl/dt_xbar_pkg.sv | 21 ++
 rtl/dt_xbar_arb.sv | 61 ++++++
 rtl/dt_xbar.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dt_xbar_pkg.sv
// dt_xbar_pkg: shared status codes, default sizes and an index-width helper
// for the dt_xbar crossbar. Build option: DT_XBAR_RR_EN selects round-robin
// arbitration per output; when undefined, lowest input index wins.
package dt_xbar_pkg;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_OK      = 2'b01;
   localparam logic [1:0] ST_CONTEND = 2'b10;

   localparam int DEF_N_IN   = 4;
   localparam int DEF_N_OUT  = 5;
   localparam int DEF_DATA_W = 16;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dt_xbar_arb.sv
// dt_xbar_arb: one N_IN-way arbiter for a single crossbar output.
// With DT_XBAR_RR_EN defined the search starts at a rotating pointer that
// moves to winner+1 after each grant; otherwise the pointer is constant 0
// (fixed priority, lowest index wins) and no state exists.
// Handshake: grant is one-hot and only asserted when en=1 and req is non-empty.
module dt_xbar_arb #(
   parameter int N_IN  = 4,
   parameter int PTR_W = 2
) (
`ifdef DT_XBAR_RR_EN
   input  logic             clk,
   input  logic             rst,
`endif
   input  logic [N_IN-1:0]  req,
   input  logic             en,
   output logic [N_IN-1:0]  grant,
   output logic             contend,
   output logic [PTR_W-1:0] ptr
);

   int   win;
   int   idx;
   logic found;

   // Find the first requester at or after the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int k = 0; k < N_IN; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_IN) idx = idx - N_IN;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // One-hot grant for the winner, plus a flag for two or more requesters.
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         grant[i] = en && found && (win == i);
      end
      contend = |(req & (req - N_IN'(1)));
   end

`ifdef DT_XBAR_RR_EN
   // Rotate the pointer past the winner on every grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (win == N_IN - 1) ? '0 : PTR_W'(win + 1);
      end
   end
`else
   assign ptr = '0;
`endif

endmodule

// File: rtl/dt_xbar.sv
// dt_xbar: N_IN x N_OUT crossbar with one registered slot per output.
// Build option: DT_XBAR_RR_EN (round-robin per output, else fixed priority).
// Handshake: an input holds in_valid/in_dest/in_data until in_ack=1 (same
// cycle, combinational); an output slot is consumed when out_valid &&
// out_ready, and may be refilled in that same cycle.
// Requests to a destination >= N_OUT are acked at once and counted as drops.
// arb_ptr exposes every output's arbiter pointer for observation.
module dt_xbar
   import dt_xbar_pkg::*;
#(
   parameter  int N_IN   = DEF_N_IN,
   parameter  int N_OUT  = DEF_N_OUT,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int DEST_W = idx_w(N_OUT),
   localparam int PTR_W  = idx_w(N_IN)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_IN-1:0]                in_valid,
   input  logic [N_IN-1:0][DEST_W-1:0]    in_dest,
   input  logic [N_IN-1:0][DATA_W-1:0]    in_data,
   output logic [N_IN-1:0]                in_ack,
   output logic [N_OUT-1:0]               out_valid,
   output logic [N_OUT-1:0][1:0]          out_status,
   output logic [N_OUT-1:0][DATA_W-1:0]   out_data,
   input  logic [N_OUT-1:0]               out_ready,
   output logic [7:0]                     drop_cnt,
   output logic [N_OUT-1:0][PTR_W-1:0]    arb_ptr
);

   logic [N_OUT-1:0][N_IN-1:0]   req;
   logic [N_OUT-1:0][N_IN-1:0]   grant;
   logic [N_OUT-1:0]             contend;
   logic [N_OUT-1:0]             en;
   logic [N_IN-1:0]              drop;
   logic [N_OUT-1:0][DATA_W-1:0] win_data;
   logic [8:0]                   drop_sum;

   // Route requests to outputs; reset suppresses every accept and drop.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         en[j] = !rst && (!out_valid[j] || out_ready[j]);
         for (int i = 0; i < N_IN; i++) begin
            req[j][i] = in_valid[i] && (int'(in_dest[i]) == j);
         end
      end
      for (int i = 0; i < N_IN; i++) begin
         drop[i] = !rst && in_valid[i] && (int'(in_dest[i]) >= N_OUT);
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_arb
      dt_xbar_arb #(
         .N_IN  (N_IN),
         .PTR_W (PTR_W)
      ) u_arb (
`ifdef DT_XBAR_RR_EN
         .clk     (clk),
         .rst     (rst),
`endif
         .req     (req[j]),
         .en      (en[j]),
         .grant   (grant[j]),
         .contend (contend[j]),
         .ptr     (arb_ptr[j])
      );
   end

   // Ack an input when any output grants it or its packet is dropped;
   // select each output's winning payload (grants are one-hot).
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         in_ack[i] = drop[i];
         for (int j = 0; j < N_OUT; j++) begin
            in_ack[i] = in_ack[i] | grant[j][i];
         end
      end
      for (int j = 0; j < N_OUT; j++) begin
         win_data[j] = '0;
         for (int i = 0; i < N_IN; i++) begin
            if (grant[j][i]) win_data[j] = in_data[i];
         end
      end
      drop_sum = {1'b0, drop_cnt};
      for (int i = 0; i < N_IN; i++) begin
         drop_sum = drop_sum + 9'(drop[i]);
      end
   end

   // Output slots: load on grant (drain+refill allowed), clear on drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= '0;
         out_status <= '0;
         out_data   <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (|grant[j]) begin
               out_valid[j]  <= 1'b1;
               out_data[j]   <= win_data[j];
               out_status[j] <= contend[j] ? ST_CONTEND : ST_OK;
            end else if (out_valid[j] && out_ready[j]) begin
               out_valid[j]  <= 1'b0;
               out_status[j] <= ST_IDLE;
            end
         end
      end
   end

   // Saturating count of invalid-destination drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_sum > 9'(DROP_MAX)) begin
         drop_cnt <= DROP_MAX;
      end else begin
         drop_cnt <= drop_sum[7:0];
      end
   end

endmodule
